pwmout_multi: RTL and testbench

Multi-channel, parametrised successor to the single-channel ESC PWM generator. Converts N per-channel speed commands into standard RC-servo/ESC pulses: a min-throttle base pulse plus a scaled speed term, repeated every frame. Adds a shared frame timebase, shadowed speed registers applied only at frame boundaries, per-channel enables, and a per-channel command-loss failsafe. Sits between the DShot decode path and the ESC output pins.

---
 rtl/pwmout_multi.sv | 138 +++++++++++++
 tb/tb_pwmout_multi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pwmout_multi.sv
`default_nettype none
// pwmout_multi: N-channel RC/ESC pulse generator sharing one frame timebase, with
// frame-boundary shadowed speed commands, per-channel enables and command-loss failsafe.
module pwmout_multi #(
  parameter int NUM_CH         = 4,
  parameter int SPEED_W        = 8,
  parameter int PRESCALE       = 12,
  parameter int PERIOD_US      = 20000,
  parameter int MIN_US         = 1000,
  parameter int RANGE_US       = 1000,
  parameter int TIMEOUT_FRAMES = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           enable,
  input  logic [NUM_CH*SPEED_W-1:0]   speed,
  input  logic [NUM_CH-1:0]           speed_valid,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        frame_start,
  output logic [NUM_CH-1:0]           failsafe
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int US_W   = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int TO_W   = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam int PROD_W = SPEED_W + $clog2(RANGE_US + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(PERIOD_US - 1);
  localparam logic [US_W-1:0]  MIN_W    = US_W'(MIN_US);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_FRAMES);

  if (MIN_US + RANGE_US > PERIOD_US) begin : g_bad_width_cfg
    $error("pwmout_multi: MIN_US + RANGE_US must not exceed PERIOD_US");
  end
  if (MIN_US < 1) begin : g_bad_min_cfg
    $error("pwmout_multi: MIN_US must be at least 1");
  end

  // Full-precision product keeps the top speed code strictly below MIN_US+RANGE_US.
  function automatic logic [US_W-1:0] calc_width(input logic [SPEED_W-1:0] s);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'(RANGE_US);
    return MIN_W + US_W'(prod >> SPEED_W);
  endfunction

  logic [PRE_W-1:0] pre_cnt;
  logic [US_W-1:0]  us_cnt;
  logic [US_W-1:0]  us_next;
  logic             tick;
  logic             boundary;

  assign tick     = (pre_cnt == PRE_LAST);
  assign boundary = tick && (us_cnt == US_LAST);

  always_comb begin
    us_next = us_cnt;
    if (boundary) begin
      us_next = '0;
    end else if (tick) begin
      us_next = us_cnt + US_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
      us_cnt      <= us_next;
      frame_start <= boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SPEED_W-1:0] shadow;
    logic [US_W-1:0]    width_act;
    logic [US_W-1:0]    width_next;
    logic [TO_W-1:0]    to_cnt;
    logic [TO_W-1:0]    to_next;
    logic               en_act;
    logic               en_next;
    logic               fs;
    logic               fs_next;
    logic               pwm_q;

    always_comb begin
      fs_next    = fs;
      to_next    = to_cnt;
      en_next    = en_act & enable[i];
      width_next = width_act;
      if (speed_valid[i]) begin
        fs_next = 1'b0;
        to_next = '0;
      end
      // The boundary latch reads the pre-write shadow, so a same-cycle command waits a frame.
      if (boundary) begin
        en_next = enable[i];
        if (!speed_valid[i] && (TIMEOUT_FRAMES != 0)) begin
          if (to_cnt != TO_MAX) begin
            to_next = to_cnt + TO_W'(1);
          end
          if (to_next == TO_MAX) begin
            fs_next = 1'b1;
          end
        end
        width_next = fs_next ? MIN_W : calc_width(shadow);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow    <= '0;
        width_act <= '0;
        to_cnt    <= '0;
        en_act    <= 1'b0;
        fs        <= 1'b0;
        pwm_q     <= 1'b0;
      end else begin
        if (speed_valid[i]) begin
          shadow <= speed[i*SPEED_W +: SPEED_W];
        end
        width_act <= width_next;
        to_cnt    <= to_next;
        en_act    <= en_next;
        fs        <= fs_next;
        pwm_q     <= en_next && enable[i] && (us_next < width_next);
      end
    end

    assign pwm_out[i]  = pwm_q;
    assign failsafe[i] = fs;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwmout_multi.sv
`default_nettype none
// tb_pwmout_multi: randomized commands/enables against a frame-level pulse model.
module tb_pwmout_multi;

  localparam int NCH   = 2;
  localparam int SW    = 8;
  localparam int PRE   = 2;
  localparam int PER   = 100;
  localparam int MINU  = 10;
  localparam int RNG   = 20;
  localparam int TO    = 3;
  localparam int FRAME = PER * PRE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    enable = '0;
  logic [NCH*SW-1:0] speed = '0;
  logic [NCH-1:0]    speed_valid = '0;
  logic [NCH-1:0]    pwm_out;
  logic              frame_start;
  logic [NCH-1:0]    failsafe;

  pwmout_multi #(
    .NUM_CH(NCH), .SPEED_W(SW), .PRESCALE(PRE), .PERIOD_US(PER),
    .MIN_US(MINU), .RANGE_US(RNG), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .speed(speed),
    .speed_valid(speed_valid), .pwm_out(pwm_out), .frame_start(frame_start),
    .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: cycles since reset release and per-channel frame bookkeeping.
  int k;
  int shadow [NCH];
  int cnt    [NCH];
  int wid    [NCH];
  bit fs     [NCH];
  bit en_ok  [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < NCH; c++) begin
      shadow[c] = 0; cnt[c] = 0; wid[c] = 0; fs[c] = 0; en_ok[c] = 0;
    end
  endtask

  function automatic logic [SW-1:0] pick_speed();
    case ($urandom_range(3, 0))
      0:       return 8'd0;
      1:       return 8'd255;
      2:       return 8'd128;
      default: return 8'($urandom_range(255, 0));
    endcase
  endfunction

  // Frame rules: width fixed at each boundary from the shadow held before that edge.
  task automatic model_edge();
    bit bnd;
    k++;
    bnd = (k % FRAME) == 0;
    for (int c = 0; c < NCH; c++) begin
      if (speed_valid[c]) begin
        cnt[c] = 0;
        fs[c]  = 0;
      end else if (bnd) begin
        if (cnt[c] < TO) cnt[c]++;
        if (cnt[c] == TO) fs[c] = 1;
      end
      if (bnd) begin
        wid[c]   = fs[c] ? MINU : MINU + (shadow[c] * RNG) / 256;
        en_ok[c] = enable[c];
      end else begin
        en_ok[c] = en_ok[c] && enable[c];
      end
      if (speed_valid[c]) shadow[c] = int'(speed[c*SW +: SW]);
    end
  endtask

  task automatic compare();
    check("frame_start", 32'(frame_start), 32'((k % FRAME) == 0));
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("pwm%0d", c), 32'(pwm_out[c]),
            32'(en_ok[c] && ((k % FRAME) < wid[c] * PRE)));
      check($sformatf("failsafe%0d", c), 32'(failsafe[c]), 32'(fs[c]));
    end
  endtask

  // One clock: drive inputs, take the edge, then compare against the model.
  task automatic step(input int valid_pm, input int en_pm,
                      input logic [NCH-1:0] force_v, input logic [SW-1:0] force_spd);
    speed_valid = '0;
    for (int c = 0; c < NCH; c++) begin
      if ($urandom_range(999, 0) < en_pm) enable[c] = ~enable[c];
      if (force_v[c]) begin
        speed_valid[c]       = 1'b1;
        speed[c*SW +: SW]    = force_spd;
      end else if ($urandom_range(999, 0) < valid_pm ||
                   (valid_pm > 0 && ((k + 1) % FRAME) == 0 && $urandom_range(1, 0) == 1)) begin
        speed_valid[c]       = 1'b1;
        speed[c*SW +: SW]    = pick_speed();
      end
    end
    @(posedge clk);
    #1;
    model_edge();
    compare();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_failsafe", 32'(failsafe), 32'd0);
    rst_n = 1'b1;

    // Channel 0 only, speed 128: 40-clock pulses from cycle 200 onward.
    enable = 2'b01;
    step(0, 0, 2'b01, 8'd128);
    repeat (450) step(0, 0, 2'b00, 8'd0);

    // Random commands, boundary-cycle commands and occasional enable toggles.
    repeat (3000) step(8, 3, 2'b00, 8'd0);

    // Command loss: both channels fall into failsafe, then channel 0 recovers.
    enable = 2'b11;
    step(0, 0, 2'b11, 8'd255);
    repeat (1000) step(0, 0, 2'b00, 8'd0);
    step(0, 0, 2'b01, 8'd128);
    repeat (400) step(0, 0, 2'b00, 8'd0);

    // Asynchronous reset in the middle of a pulse.
    while ((k % FRAME) != 10) step(0, 0, 2'b00, 8'd0);
    check("pre_rst_pwm0", 32'(pwm_out[0]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_failsafe", 32'(failsafe), 32'd0);
    check("async_rst_frame_start", 32'(frame_start), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (1000) step(8, 3, 2'b00, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
